divider_scheduler: RTL

Shares one pipelined unsigned array divider among NUM_REQ requesters. Arbitration is round-robin, with at most one issue per cycle. An in-order tag FIFO returns each quotient and remainder to the requester that issued the operation. The block sits between the requester ports and the divider's i_valid/A/B inputs and o_valid/Q_out/R_out outputs.

---
 rtl/divider_scheduler.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/divider_scheduler.sv
// Round-robin front end sharing one pipelined divider among NUM_REQ requesters, with an
// in-order tag FIFO routing results back. Optional macro DIV_SCHED_DZ_EN adds divide-by-zero override.
module divider_scheduler #(
    parameter int DATAWIDTH           = 16,
    parameter int NUM_REQ             = 4,
    parameter int NUM_PIPELINE_STAGES = 17
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*DATAWIDTH-1:0]   req_a,
    input  logic [NUM_REQ*DATAWIDTH-1:0]   req_b,
    output logic                           div_valid,
    output logic [DATAWIDTH-1:0]           div_a,
    output logic [DATAWIDTH-1:0]           div_b,
    input  logic                           div_o_valid,
    input  logic [DATAWIDTH-1:0]           div_q,
    input  logic [DATAWIDTH-1:0]           div_r,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [DATAWIDTH-1:0]           rsp_q,
    output logic [DATAWIDTH-1:0]           rsp_r,
    output logic                           busy,
    output logic                           err_underflow
`ifdef DIV_SCHED_DZ_EN
    ,
    output logic                           rsp_dz
`endif
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int DEPTH = NUM_PIPELINE_STAGES + 2;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
`ifdef DIV_SCHED_DZ_EN
    localparam int ENT_W = ID_W + 1 + DATAWIDTH;
`else
    localparam int ENT_W = ID_W;
`endif

    logic [ID_W-1:0]      r_rr_ptr;
    logic [PTR_W-1:0]     r_wptr;
    logic [PTR_W-1:0]     r_rptr;
    logic [CNT_W-1:0]     r_count;
    logic [ENT_W-1:0]     r_mem [DEPTH];
    logic                 r_div_valid;
    logic [DATAWIDTH-1:0] r_div_a;
    logic [DATAWIDTH-1:0] r_div_b;
    logic [NUM_REQ-1:0]   r_rsp_valid;
    logic [DATAWIDTH-1:0] r_rsp_q;
    logic [DATAWIDTH-1:0] r_rsp_r;
    logic                 r_err;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_found;
    logic [ID_W-1:0]      w_gnt;
    logic [DATAWIDTH-1:0] w_sel_a;
    logic [DATAWIDTH-1:0] w_sel_b;
    logic [ENT_W-1:0]     w_push_entry;
    logic [ENT_W-1:0]     w_head;
    logic [ID_W-1:0]      w_head_tag;
    logic [NUM_REQ-1:0]   w_head_onehot;
    logic [DATAWIDTH-1:0] w_out_q;
    logic [DATAWIDTH-1:0] w_out_r;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_pop   = div_o_valid && !w_empty;

    // Scan upward from the round-robin pointer, wrapping at NUM_REQ.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = int'(r_rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!w_found && req_valid[idx]) begin
                w_found = 1'b1;
                w_gnt   = ID_W'(idx);
            end
        end
    end

    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign w_push = w_found && (!w_full || div_o_valid);

    always_comb begin
        req_ready = '0;
        if (w_push) req_ready[w_gnt] = 1'b1;
    end

    assign w_sel_a = req_a[w_gnt*DATAWIDTH +: DATAWIDTH];
    assign w_sel_b = req_b[w_gnt*DATAWIDTH +: DATAWIDTH];
    assign w_head  = r_mem[r_rptr];
    assign w_head_tag = w_head[ID_W-1:0];

`ifdef DIV_SCHED_DZ_EN
    logic r_rsp_dz;
    logic w_head_dz;
    assign w_push_entry = {w_sel_a, (w_sel_b == '0), w_gnt};
    assign w_head_dz    = w_head[ID_W];
    assign w_out_q      = w_head_dz ? {DATAWIDTH{1'b1}} : div_q;
    assign w_out_r      = w_head_dz ? w_head[ID_W+1 +: DATAWIDTH] : div_r;
    assign rsp_dz       = r_rsp_dz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_dz <= 1'b0;
        end else if (w_pop) begin
            r_rsp_dz <= w_head_dz;
        end
    end
`else
    assign w_push_entry = w_gnt;
    assign w_out_q      = div_q;
    assign w_out_r      = div_r;
`endif

    always_comb begin
        w_head_onehot = '0;
        w_head_onehot[w_head_tag] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= w_push_entry;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr    <= '0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_div_valid <= 1'b0;
            r_div_a     <= '0;
            r_div_b     <= '0;
            r_rsp_valid <= '0;
            r_rsp_q     <= '0;
            r_rsp_r     <= '0;
            r_err       <= 1'b0;
        end else begin
            r_div_valid <= w_push;
            if (w_push) begin
                r_rr_ptr <= (w_gnt == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt + 1'b1;
                r_wptr   <= (r_wptr == PTR_W'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
                r_div_a  <= w_sel_a;
                r_div_b  <= w_sel_b;
            end
            if (w_pop) begin
                r_rptr  <= (r_rptr == PTR_W'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;
                r_rsp_q <= w_out_q;
                r_rsp_r <= w_out_r;
            end
            r_rsp_valid <= w_pop ? w_head_onehot : '0;
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            if (div_o_valid && w_empty) r_err <= 1'b1;
        end
    end

    assign div_valid     = r_div_valid;
    assign div_a         = r_div_a;
    assign div_b         = r_div_b;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_q         = r_rsp_q;
    assign rsp_r         = r_rsp_r;
    assign busy          = !w_empty;
    assign err_underflow = r_err;

endmodule
